rtype: RTL and testbench
========================

Name: rtype

Overview:
Single-cycle MIPS R-type execution slice: a 32x32 register file plus an ALU.
- Decodes a 32-bit R-format instruction, reads rs/rt combinationally, computes the result combinationally, and writes it to rd on the rising clock edge.
- Sits as the register-file/execute stage of the lab CPU datapath; the instruction is driven externally, one per clock.

Parameters:
none (data width fixed 32, register count fixed 32, register index width fixed 5)

Ports:
clock        input   1   system clock; all state updates on rising edge
reset_n      input   1   synchronous active-low reset
instruction  input   32  R-format instruction: op[31:26] rs[25:21] rt[20:16] rd[15:11] shamt[10:6] funct[5:0]
a_data       output  32  register file read port A = regs[rs], combinational
b_data       output  32  register file read port B = regs[rt], combinational
result       output  32  ALU result for current instruction, combinational

Behaviour:
Interface:
- One clock; reset is synchronous and active-low (reset_n sampled on rising edge of clock).

Reset:
- On a rising edge with reset_n=0, every register i is loaded with the value i (regs[0]=0, regs[13]=13, ...).
- Reset has priority over any write in the same cycle.
- Outputs are combinational functions of registers and instruction, so after reset they reflect the reset contents.

Read path:
- a_data=regs[rs], b_data=regs[rt]; register 0 always reads 0.
- No write-to-read bypass: the old value is visible until the edge that performs the write.

ALU, selected by funct when op==0; all arithmetic is 32-bit wrap-around, with no overflow trap:
- 0x20 add, 0x21 addu: a+b
- 0x22 sub, 0x23 subu: a-b
- 0x24 and, 0x25 or, 0x26 xor, 0x27 nor (~(a|b))
- 0x2A slt: signed a<b, giving 1 or 0
- 0x2B sltu: unsigned a<b, giving 1 or 0
- 0x00 sll, 0x02 srl, 0x03 sra: b shifted by shamt
- 0x04 sllv, 0x06 srlv, 0x07 srav: b shifted by a[4:0]
- sra/srav are arithmetic (sign-filling).

Write-back:
- On a rising edge with reset_n=1, op==0, funct supported and rd!=0: regs[rd] <= result.
- Latency: result is visible in the same cycle; the written value is readable from the next cycle.

Boundary conditions:
- rd==0: no write; register 0 stays 0.
- op!=0 or unsupported funct: result=0, no write.
- rs==rt: both ports return the same register.
- rd==rs: the read returns the pre-edge value; the update is seen after the edge.
- reset_n low mid-sequence: all registers reinitialise at that edge; the pending write is discarded.

Decomposition:
- Package rtype_pkg holds:
  - funct code constants (FUNCT_ADD, FUNCT_SUB, ...)
  - OP_RTYPE=6'h00
  - field bit positions
  - an enum for ALU operation
- One sub-module is natural: rtype_alu, purely combinational, with inputs a, b, shamt, funct and outputs result and valid.
- The register file stays in the top level.

Test Plan:
- Reset, then instruction 0x01A88020 (add $16,$13,$8) -> a_data=13, b_data=8, result=21; after the edge regs[16]=21.
- 0x01C98822 (sub $17,$14,$9) -> a=14, b=9, result=5.
- 0x01EA9024 (and $18,$15,$10) -> result=10.
- 0x030B9825 (or $19,$24,$11) -> result=27.
- 0x032CA02A (slt $20,$25,$12) -> a=25, b=12, result=0. Then 0x0200A820 (add $21,$16,$0) -> a_data=21, confirming the earlier write-back.
- Write to $0 (rd=0, e.g. add $0,$13,$8) -> no change, reads of $0 stay 0. A sub that yields 1-2 gives 0xFFFFFFFF; slt on it against 0 gives 1. Assert reset_n=0 after writes -> regs[16] returns to 16.

Source files
------------

// File: rtl/rtype_pkg.sv
// Shared definitions for the R-type execution slice: field positions,
// funct codes and the ALU operation encoding.
package rtype_pkg;

  localparam int DATA_W = 32;
  localparam int REG_N  = 32;
  localparam int IDX_W  = 5;

  localparam int OP_MSB    = 31;
  localparam int OP_LSB    = 26;
  localparam int RS_MSB    = 25;
  localparam int RS_LSB    = 21;
  localparam int RT_MSB    = 20;
  localparam int RT_LSB    = 16;
  localparam int RD_MSB    = 15;
  localparam int RD_LSB    = 11;
  localparam int SHAMT_MSB = 10;
  localparam int SHAMT_LSB = 6;
  localparam int FUNCT_MSB = 5;
  localparam int FUNCT_LSB = 0;

  localparam logic [5:0] OP_RTYPE = 6'h00;

  localparam logic [5:0] FUNCT_SLL  = 6'h00;
  localparam logic [5:0] FUNCT_SRL  = 6'h02;
  localparam logic [5:0] FUNCT_SRA  = 6'h03;
  localparam logic [5:0] FUNCT_SLLV = 6'h04;
  localparam logic [5:0] FUNCT_SRLV = 6'h06;
  localparam logic [5:0] FUNCT_SRAV = 6'h07;
  localparam logic [5:0] FUNCT_ADD  = 6'h20;
  localparam logic [5:0] FUNCT_ADDU = 6'h21;
  localparam logic [5:0] FUNCT_SUB  = 6'h22;
  localparam logic [5:0] FUNCT_SUBU = 6'h23;
  localparam logic [5:0] FUNCT_AND  = 6'h24;
  localparam logic [5:0] FUNCT_OR   = 6'h25;
  localparam logic [5:0] FUNCT_XOR  = 6'h26;
  localparam logic [5:0] FUNCT_NOR  = 6'h27;
  localparam logic [5:0] FUNCT_SLT  = 6'h2A;
  localparam logic [5:0] FUNCT_SLTU = 6'h2B;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
    ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_NONE
  } alu_op_e;

  function automatic alu_op_e decode_funct(input logic [5:0] f);
    alu_op_e op;
    case (f)
      FUNCT_ADD, FUNCT_ADDU:  op = ALU_ADD;
      FUNCT_SUB, FUNCT_SUBU:  op = ALU_SUB;
      FUNCT_AND:              op = ALU_AND;
      FUNCT_OR:               op = ALU_OR;
      FUNCT_XOR:              op = ALU_XOR;
      FUNCT_NOR:              op = ALU_NOR;
      FUNCT_SLT:              op = ALU_SLT;
      FUNCT_SLTU:             op = ALU_SLTU;
      FUNCT_SLL, FUNCT_SLLV:  op = ALU_SLL;
      FUNCT_SRL, FUNCT_SRLV:  op = ALU_SRL;
      FUNCT_SRA, FUNCT_SRAV:  op = ALU_SRA;
      default:                op = ALU_NONE;
    endcase
    return op;
  endfunction

  function automatic logic is_var_shift(input logic [5:0] f);
    return (f == FUNCT_SLLV) || (f == FUNCT_SRLV) || (f == FUNCT_SRAV);
  endfunction

endpackage

// File: rtl/rtype_alu.sv
// Combinational R-type ALU; valid flags a supported funct code.
module rtype_alu
  import rtype_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [4:0]        shamt,
  input  logic [5:0]        funct,
  output logic [DATA_W-1:0] result,
  output logic              valid
);

  alu_op_e                  op;
  logic signed [DATA_W-1:0] a_s;
  logic signed [DATA_W-1:0] b_s;
  logic [4:0]               sh;

  always_comb begin
    op     = decode_funct(funct);
    a_s    = a;
    b_s    = b;
    // Variable shifts take the amount from the low bits of rs.
    sh     = is_var_shift(funct) ? a[4:0] : shamt;
    valid  = (op != ALU_NONE);
    result = '0;
    case (op)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_XOR:  result = a ^ b;
      ALU_NOR:  result = ~(a | b);
      ALU_SLT:  result = {{(DATA_W-1){1'b0}}, (a_s < b_s)};
      ALU_SLTU: result = {{(DATA_W-1){1'b0}}, (a < b)};
      ALU_SLL:  result = b << sh;
      ALU_SRL:  result = b >> sh;
      ALU_SRA:  result = b_s >>> sh;
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/rtype.sv
// Single-cycle R-type slice: 32x32 register file with combinational reads,
// ALU, and write-back to rd on the rising clock edge.
module rtype
  import rtype_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] instruction,
  output logic [DATA_W-1:0] a_data,
  output logic [DATA_W-1:0] b_data,
  output logic [DATA_W-1:0] result
);

  logic [5:0]       op;
  logic [IDX_W-1:0] rs;
  logic [IDX_W-1:0] rt;
  logic [IDX_W-1:0] rd;
  logic [4:0]       shamt;
  logic [5:0]       funct;

  logic [DATA_W-1:0] regs [REG_N];
  logic [DATA_W-1:0] alu_result;
  logic              alu_valid;
  logic              exec_ok;
  logic              wr_en;

  assign op    = instruction[OP_MSB:OP_LSB];
  assign rs    = instruction[RS_MSB:RS_LSB];
  assign rt    = instruction[RT_MSB:RT_LSB];
  assign rd    = instruction[RD_MSB:RD_LSB];
  assign shamt = instruction[SHAMT_MSB:SHAMT_LSB];
  assign funct = instruction[FUNCT_MSB:FUNCT_LSB];

  // No bypass: reads always see the pre-edge register contents.
  assign a_data = (rs == '0) ? '0 : regs[rs];
  assign b_data = (rt == '0) ? '0 : regs[rt];

  rtype_alu u_alu (
    .a      (a_data),
    .b      (b_data),
    .shamt  (shamt),
    .funct  (funct),
    .result (alu_result),
    .valid  (alu_valid)
  );

  assign exec_ok = (op == OP_RTYPE) && alu_valid;
  assign result  = exec_ok ? alu_result : '0;
  assign wr_en   = exec_ok && (rd != '0);

  // Reset loads each register with its own index and overrides any write.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < REG_N; i++) regs[i] <= DATA_W'(i);
    end else if (wr_en) begin
      regs[rd] <= result;
    end
  end

endmodule

// File: tb/tb_rtype.sv
// Bench for rtype: directed instruction sequence with literal expectations,
// then randomized instructions checked every cycle against a reference model.
module tb_rtype;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [31:0] instruction;
  logic [31:0] a_data, b_data, result;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 0;

  logic [31:0] m_regs [32];

  rtype dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .instruction (instruction),
    .a_data      (a_data),
    .b_data      (b_data),
    .result      (result)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t instr=0x%08h)",
               name, act, exp, $time, instruction);
    end
  endtask

  // Reference: what an R-type instruction computes, from the instruction set rules.
  function automatic void model_eval(input logic [31:0] ins,
                                     output logic [31:0] ea, output logic [31:0] eb,
                                     output logic [31:0] er, output bit we);
    int unsigned rs, rt, rd, sh;
    logic [31:0] a, b, r;
    bit ok;
    rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11]; sh = ins[10:6];
    a = (rs == 0) ? 32'd0 : m_regs[rs];
    b = (rt == 0) ? 32'd0 : m_regs[rt];
    ok = 1;
    r  = 32'd0;
    case (ins[5:0])
      6'h20, 6'h21: r = a + b;
      6'h22, 6'h23: r = a - b;
      6'h24: r = a & b;
      6'h25: r = a | b;
      6'h26: r = a ^ b;
      6'h27: r = ~(a | b);
      6'h2A: r = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      6'h2B: r = (a < b) ? 32'd1 : 32'd0;
      6'h00: r = b << sh;
      6'h02: r = b >> sh;
      6'h03: r = 32'(int'(b) >>> sh);
      6'h04: r = b << a[4:0];
      6'h06: r = b >> a[4:0];
      6'h07: r = 32'(int'(b) >>> a[4:0]);
      default: ok = 0;
    endcase
    if (ins[31:26] != 6'h00) ok = 0;
    er = ok ? r : 32'd0;
    we = ok && (rd != 0);
    ea = a;
    eb = b;
  endfunction

  // Model state update at the active edge.
  always @(posedge clock) begin
    logic [31:0] ea, eb, er;
    bit we;
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'(i);
    end else if (chk_en) begin
      model_eval(instruction, ea, eb, er, we);
      if (we) m_regs[instruction[15:11]] = er;
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clock) begin
    logic [31:0] ea, eb, er;
    bit we;
    if (chk_en) begin
      model_eval(instruction, ea, eb, er, we);
      check("model_a", a_data, ea);
      check("model_b", b_data, eb);
      check("model_result", result, er);
    end
  end

  task automatic apply(input logic [31:0] ins);
    instruction = ins;
    #2;
  endtask

  task automatic next_edge();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] enc(input int unsigned rs, rt, rd, sh, input logic [5:0] f);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), f};
  endfunction

  logic [5:0] funct_tab [16] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                                 6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07};

  initial begin
    logic [31:0] ins;
    reset_n     = 1'b0;
    instruction = 32'd0;
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    chk_en  = 1;

    // Reset contents are visible through the read ports.
    apply(enc(31, 7, 0, 0, 6'h20));
    check("reset_r31", a_data, 32'd31);
    check("reset_r7", b_data, 32'd7);

    apply(32'h01A88020);
    check("add_a", a_data, 32'd13);
    check("add_b", b_data, 32'd8);
    check("add_res", result, 32'd21);
    next_edge();
    apply(32'h01C98822);
    check("sub_a", a_data, 32'd14);
    check("sub_b", b_data, 32'd9);
    check("sub_res", result, 32'd5);
    next_edge();
    apply(32'h01EA9024);
    check("and_res", result, 32'd10);
    next_edge();
    apply(32'h030B9825);
    check("or_res", result, 32'd27);
    next_edge();
    apply(32'h032CA02A);
    check("slt_a", a_data, 32'd25);
    check("slt_b", b_data, 32'd12);
    check("slt_res", result, 32'd0);
    next_edge();
    apply(32'h0200A820);
    check("wb_r16", a_data, 32'd21);
    check("wb_res", result, 32'd21);
    next_edge();
    apply(32'h01A80020);
    check("r0_write_res", result, 32'd21);
    next_edge();
    apply(32'h00000020);
    check("r0_a", a_data, 32'd0);
    check("r0_res", result, 32'd0);
    next_edge();
    apply(32'h0022B022);
    check("neg_res", result, 32'hFFFF_FFFF);
    next_edge();
    apply(32'h02C0B82A);
    check("neg_a", a_data, 32'hFFFF_FFFF);
    check("slt_neg", result, 32'd1);
    next_edge();
    // rd == rs: old value this cycle, updated value after the edge.
    apply(32'h00A52820);
    check("rdrs_pre", result, 32'd10);
    next_edge();
    apply(32'h00A52820);
    check("rdrs_post", a_data, 32'd10);
    check("rdrs_res", result, 32'd20);
    next_edge();
    apply(32'hFC000020);
    check("op_nz_res", result, 32'd0);
    apply(enc(13, 8, 3, 0, 6'h3F));
    check("bad_funct_res", result, 32'd0);
    apply(enc(0, 25, 4, 4, 6'h03));
    check("sra_pos", result, 32'd1);
    apply(enc(24, 23, 4, 31, 6'h00));
    check("sll_31", result, 32'h8000_0000);
    // Reset mid-sequence discards the pending write and restores indices.
    apply(enc(13, 8, 16, 0, 6'h20));
    reset_n = 1'b0;
    next_edge();
    reset_n = 1'b1;
    apply(32'h02000820);
    check("rst_r16", a_data, 32'd16);
    apply(enc(22, 5, 0, 0, 6'h20));
    check("rst_r22", a_data, 32'd22);
    check("rst_r5", b_data, 32'd5);
    next_edge();

    // Randomized phase.
    for (int n = 0; n < 600; n++) begin
      ins = enc($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                $urandom_range(0, 31), funct_tab[$urandom_range(0, 15)]);
      if ($urandom_range(0, 19) == 0) ins[5:0] = 6'($urandom);
      if ($urandom_range(0, 29) == 0) ins[31:26] = 6'($urandom);
      reset_n = ($urandom_range(0, 59) == 0) ? 1'b0 : 1'b1;
      apply(ins);
      next_edge();
    end
    reset_n = 1'b1;
    next_edge();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
